uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, clock cycles per UART bit (12 MHz / 9600 baud).
REQ-002 Parameter TIMEOUT_CLKS, default 24000, maximum idle cycles between bytes inside one frame.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  UART serial line, 8N1, idle high, LSB first.
REQ-006 led_out  output  1  LED state from the last good frame.
REQ-007 buzzer_out  output  1  buzzer state from the last good frame.
REQ-008 seg7_out  output  7  seven-segment pattern (a-g) from the last good frame.
REQ-009 frame_valid  output  1  one-cycle pulse when a complete good frame is accepted.
REQ-010 frame_err  output  1  one-cycle pulse when a frame is aborted.
REQ-011 frame_cnt  output  8  count of good frames, wraps 255->0.
REQ-012 err_cnt  output  8  count of aborted frames, saturates at 255.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-014 Byte receiver states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE->START SHALL occur on the synchronized rx falling edge.
REQ-016 START SHALL wait CLKS_PER_BIT/2 cycles, then: rx low -> DATA; rx high -> IDLE (false start, no byte, no error).
REQ-017 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals, LSB first, then enter STOP.
REQ-018 STOP SHALL sample rx after CLKS_PER_BIT cycles: high -> internal byte strobe next cycle; low -> framing error strobe, byte discarded; both return to IDLE.
REQ-019 Frame format SHALL be six bytes: 0x61, L, 0x62, B, 0x63, S.
REQ-020 Parser states SHALL be WAIT_A, GET_L, WAIT_B, GET_B, WAIT_C, GET_S.
REQ-021 WAIT_A SHALL ignore every byte except 0x61; on 0x61 it SHALL go to GET_L; no error is raised in WAIT_A.
REQ-022 GET_L and GET_B SHALL accept only 0x00 or 0x01, capturing bit0 into a shadow register.
REQ-023 GET_S SHALL accept only bytes with bit7 = 0, capturing bits[6:0] into a shadow register.
REQ-024 WAIT_B SHALL accept only 0x62; WAIT_C SHALL accept only 0x63.
REQ-025 Any rejected byte outside WAIT_A SHALL pulse frame_err; the parser SHALL go to GET_L if that byte is 0x61, else to WAIT_A.
REQ-026 A framing-error strobe outside WAIT_A SHALL pulse frame_err and return the parser to WAIT_A; in WAIT_A it SHALL be ignored.
REQ-027 An idle counter SHALL run in every state except WAIT_A and clear on each byte strobe; reaching TIMEOUT_CLKS SHALL pulse frame_err and return the parser to WAIT_A.
REQ-028 On an accepted S byte, led_out, buzzer_out and seg7_out SHALL update together from the shadow registers, frame_valid SHALL pulse and frame_cnt SHALL increment, all in the cycle after the byte strobe; the parser SHALL then go to WAIT_A.
REQ-029 Outputs SHALL never reflect a partial frame; an aborted frame SHALL leave them unchanged.
REQ-030 err_cnt SHALL increment on every frame_err pulse and saturate at 255.
REQ-031 frame_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-032 While rst is high: synchronizer flops = 1; receiver in IDLE; parser in WAIT_A; led_out = 0, buzzer_out = 0, seg7_out = 7'b0000001, frame_valid = 0, frame_err = 0, frame_cnt = 0, err_cnt = 0.
REQ-033 Reset mid-byte or mid-frame SHALL discard all partial data, with no frame_err pulse.

Verification
REQ-034 Bytes 61 01 62 01 63 4F -> one frame_valid pulse; led_out=1, buzzer_out=1, seg7_out=7'h4F, frame_cnt=1, err_cnt=0.
REQ-035 Good frame, then 61 01 62 with stop bit of 0x62 driven low -> frame_err pulse, err_cnt=1, outputs keep previous values.
REQ-036 Bytes 61 05 -> frame_err on 05; then 61 00 62 00 63 01 -> frame_valid; led_out=0, buzzer_out=0, seg7_out=7'h01.
REQ-037 rx low glitch lasting CLKS_PER_BIT/4 -> no byte strobe, no frame_valid, no frame_err.
REQ-038 Bytes 61 01, then rx idle for TIMEOUT_CLKS+10 cycles -> exactly one frame_err pulse; outputs unchanged.
REQ-039 rst pulsed during the DATA bits of byte 4 -> outputs at reset values immediately; next complete frame decodes with frame_cnt=1.

Source files
------------

// File: rtl/uart_frame_rx.sv
// 8N1 UART byte receiver feeding a six-byte command-frame parser
// ('a' L 'b' B 'c' S) that drives LED, buzzer and seven-segment outputs.
module uart_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned TIMEOUT_CLKS = 24000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       led_out,
  output logic       buzzer_out,
  output logic [6:0] seg7_out,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  localparam int unsigned BIT_CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDLE_CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST     = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0]  HALF_LAST    = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] HDR_A = 8'h61;
  localparam logic [7:0] HDR_B = 8'h62;
  localparam logic [7:0] HDR_C = 8'h63;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_A, GET_L, WAIT_B, GET_B, WAIT_C, GET_S} ps_state_t;

  logic                  rx_meta, rx_sync, rx_prev;
  rx_state_t             rx_state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic                  byte_stb, ferr_stb;
  logic [7:0]            byte_data;

  ps_state_t             ps;
  logic [IDLE_CNT_W-1:0] idle_cnt;
  logic                  sh_led, sh_buz;
  logic                  byte_ok;
  logic [7:0]            err_cnt_sat;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte receiver: start bit re-checked at mid-bit, data/stop sampled one bit apart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      ferr_stb  <= 1'b0;
      byte_data <= '0;
    end else begin
      byte_stb <= 1'b0;
      ferr_stb <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= START;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= STOP;
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_state <= IDLE;
            if (rx_sync) begin
              byte_stb  <= 1'b1;
              byte_data <= shreg;
            end else begin
              ferr_stb <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Which byte values the current parser position will accept
  always_comb begin
    byte_ok = 1'b0;
    case (ps)
      WAIT_A:       byte_ok = (byte_data == HDR_A);
      GET_L, GET_B: byte_ok = (byte_data[7:1] == 7'd0);
      WAIT_B:       byte_ok = (byte_data == HDR_B);
      WAIT_C:       byte_ok = (byte_data == HDR_C);
      GET_S:        byte_ok = !byte_data[7];
      default:      byte_ok = 1'b0;
    endcase
  end

  assign err_cnt_sat = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  // Frame parser; visible outputs only move when the final S byte is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps          <= WAIT_A;
      idle_cnt    <= '0;
      sh_led      <= 1'b0;
      sh_buz      <= 1'b0;
      led_out     <= 1'b0;
      buzzer_out  <= 1'b0;
      seg7_out    <= 7'b0000001;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (byte_stb) begin
        idle_cnt <= '0;
        if (byte_ok) begin
          case (ps)
            WAIT_A: ps <= GET_L;
            GET_L: begin
              sh_led <= byte_data[0];
              ps     <= WAIT_B;
            end
            WAIT_B: ps <= GET_B;
            GET_B: begin
              sh_buz <= byte_data[0];
              ps     <= WAIT_C;
            end
            WAIT_C: ps <= GET_S;
            GET_S: begin
              led_out     <= sh_led;
              buzzer_out  <= sh_buz;
              seg7_out    <= byte_data[6:0];
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
              ps          <= WAIT_A;
            end
            default: ps <= WAIT_A;
          endcase
        end else if (ps != WAIT_A) begin
          frame_err <= 1'b1;
          err_cnt   <= err_cnt_sat;
          ps        <= (byte_data == HDR_A) ? GET_L : WAIT_A;
        end
      end else if (ferr_stb && ps != WAIT_A) begin
        frame_err <= 1'b1;
        err_cnt   <= err_cnt_sat;
        idle_cnt  <= '0;
        ps        <= WAIT_A;
      end else if (ps != WAIT_A) begin
        if (idle_cnt == TIMEOUT_LAST) begin
          frame_err <= 1'b1;
          err_cnt   <= err_cnt_sat;
          idle_cnt  <= '0;
          ps        <= WAIT_A;
        end else begin
          idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: fixed frame vectors, corner sequences and random
// frames checked against a queue-based frame model.
module tb_uart_frame_rx;

  localparam int unsigned CPB = 8;
  localparam int unsigned TMO = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       led_out, buzzer_out, frame_valid, frame_err;
  logic [6:0] seg7_out;
  logic [7:0] frame_cnt, err_cnt;

  uart_frame_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .led_out(led_out), .buzzer_out(buzzer_out), .seg7_out(seg7_out),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int mon_valid = 0;
  int mon_err = 0;
  int mon_both = 0;

  // Count output pulses on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) mon_valid++;
      if (frame_err) mon_err++;
      if (frame_valid && frame_err) mon_both++;
    end
  end

  // Reference model: bytes of the frame in progress, committed at six
  logic [7:0] m_buf[$];
  logic       m_led, m_buz;
  logic [6:0] m_seg;
  logic [7:0] m_fcnt;
  int         m_ecnt, m_valid, m_err;

  function automatic bit fits(int pos, logic [7:0] b);
    case (pos)
      0: return b == 8'h61;
      1, 3: return b <= 8'h01;
      2: return b == 8'h62;
      4: return b == 8'h63;
      5: return b < 8'h80;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_abort();
    if (m_buf.size() > 0) begin
      m_err++;
      m_ecnt++;
      m_buf.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (fits(m_buf.size(), b)) begin
      m_buf.push_back(b);
      if (m_buf.size() == 6) begin
        m_led = m_buf[1][0];
        m_buz = m_buf[3][0];
        m_seg = m_buf[5][6:0];
        m_fcnt = m_fcnt + 8'd1;
        m_valid++;
        m_buf.delete();
      end
    end else if (m_buf.size() > 0) begin
      model_abort();
      if (b == 8'h61) m_buf.push_back(b);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_led = 1'b0;
    m_buz = 1'b0;
    m_seg = 7'h01;
    m_fcnt = 8'd0;
    m_ecnt = 0;
  endtask

  function automatic int sat255(int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".led"}, 32'(led_out), 32'(m_led));
    check({tag, ".buzzer"}, 32'(buzzer_out), 32'(m_buz));
    check({tag, ".seg7"}, 32'(seg7_out), 32'(m_seg));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_fcnt));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(sat255(m_ecnt)));
    check({tag, ".valid_pulses"}, 32'(mon_valid), 32'(m_valid));
    check({tag, ".err_pulses"}, 32'(mon_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  // Drive one 8N1 character; stop_ok=0 drives a low stop bit
  task automatic tx(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    rx = 1'b1;
    if (stop_ok) model_byte(b);
    else begin
      model_abort();
      idle(CPB);
    end
    idle(2);
  endtask

  typedef struct {
    int               n;
    logic [0:7][7:0]  b;
    logic [7:0]       stop_low;
    logic             e_led;
    logic             e_buz;
    logic [6:0]       e_seg;
    logic [7:0]       e_fcnt;
    logic [7:0]       e_ecnt;
    int               d_valid;
    int               d_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    int base_v, base_e;
    logic [7:0] fr[6];
    logic [7:0] bb;
    int r;

    vt[0] = '{6, {8'h61, 8'h01, 8'h62, 8'h01, 8'h63, 8'h4F, 8'h00, 8'h00}, 8'h00, 1'b1, 1'b1, 7'h4F, 8'd1, 8'd0, 1, 0};
    vt[1] = '{3, {8'h61, 8'h01, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h04, 1'b1, 1'b1, 7'h4F, 8'd1, 8'd1, 0, 1};
    vt[2] = '{2, {8'h61, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b1, 1'b1, 7'h4F, 8'd1, 8'd2, 0, 1};
    vt[3] = '{6, {8'h61, 8'h00, 8'h62, 8'h00, 8'h63, 8'h01, 8'h00, 8'h00}, 8'h00, 1'b0, 1'b0, 7'h01, 8'd2, 8'd2, 1, 0};
    vt[4] = '{8, {8'h62, 8'h63, 8'h61, 8'h00, 8'h62, 8'h01, 8'h63, 8'h7F}, 8'h00, 1'b0, 1'b1, 7'h7F, 8'd3, 8'd2, 1, 0};
    vt[5] = '{8, {8'h61, 8'h01, 8'h61, 8'h00, 8'h62, 8'h01, 8'h63, 8'h12}, 8'h00, 1'b0, 1'b1, 7'h12, 8'd4, 8'd3, 1, 1};
    vt[6] = '{6, {8'h61, 8'h00, 8'h62, 8'h00, 8'h63, 8'h80, 8'h00, 8'h00}, 8'h00, 1'b0, 1'b1, 7'h12, 8'd4, 8'd4, 0, 1};
    vt[7] = '{7, {8'h55, 8'h61, 8'h01, 8'h62, 8'h01, 8'h63, 8'h00, 8'h00}, 8'h01, 1'b1, 1'b1, 7'h00, 8'd5, 8'd4, 1, 0};

    m_valid = 0;
    m_err = 0;
    model_reset();
    rst = 1'b1;
    rx = 1'b1;
    idle(3);
    check("reset.led", 32'(led_out), 32'd0);
    check("reset.seg7", 32'(seg7_out), 32'h01);
    check("reset.pulses", 32'({frame_valid, frame_err}), 32'd0);
    rst = 1'b0;
    idle(4);

    // Hand-derived frame vectors
    for (int v = 0; v < 8; v++) begin
      base_v = mon_valid;
      base_e = mon_err;
      for (int i = 0; i < vt[v].n; i++) tx(vt[v].b[i], !vt[v].stop_low[i]);
      idle(CPB);
      check($sformatf("vec%0d.led", v), 32'(led_out), 32'(vt[v].e_led));
      check($sformatf("vec%0d.buzzer", v), 32'(buzzer_out), 32'(vt[v].e_buz));
      check($sformatf("vec%0d.seg7", v), 32'(seg7_out), 32'(vt[v].e_seg));
      check($sformatf("vec%0d.frame_cnt", v), 32'(frame_cnt), 32'(vt[v].e_fcnt));
      check($sformatf("vec%0d.err_cnt", v), 32'(err_cnt), 32'(vt[v].e_ecnt));
      check($sformatf("vec%0d.valid_delta", v), 32'(mon_valid - base_v), 32'(vt[v].d_valid));
      check($sformatf("vec%0d.err_delta", v), 32'(mon_err - base_e), 32'(vt[v].d_err));
    end

    // Short low glitch mid-frame must not produce a byte
    tx(8'h61, 1'b1);
    base_e = mon_err;
    rx = 1'b0;
    idle(CPB / 4);
    rx = 1'b1;
    idle(3 * CPB);
    check("glitch.err_delta", 32'(mon_err - base_e), 32'd0);
    base_v = mon_valid;
    tx(8'h00, 1'b1); tx(8'h62, 1'b1); tx(8'h01, 1'b1); tx(8'h63, 1'b1); tx(8'h05, 1'b1);
    check("glitch.valid_delta", 32'(mon_valid - base_v), 32'd1);
    check_model("glitch");

    // Inter-byte timeout inside a frame
    base_e = mon_err;
    tx(8'h61, 1'b1);
    tx(8'h01, 1'b1);
    idle(TMO + 10);
    model_abort();
    check("timeout.err_delta", 32'(mon_err - base_e), 32'd1);
    check_model("timeout");

    // Random frames with occasional corrupt bytes and framing errors
    for (int f = 0; f < 25; f++) begin
      fr[0] = 8'h61;
      fr[1] = 8'($urandom_range(0, 1));
      fr[2] = 8'h62;
      fr[3] = 8'($urandom_range(0, 1));
      fr[4] = 8'h63;
      fr[5] = 8'($urandom_range(0, 127));
      for (int i = 0; i < 6; i++) begin
        r = $urandom_range(0, 19);
        bb = (r == 0) ? 8'($urandom_range(0, 255)) : fr[i];
        tx(bb, r != 1);
        idle($urandom_range(0, 2) * CPB);
      end
      check_model($sformatf("rand%0d", f));
    end
    idle(TMO + 20);
    model_abort();
    check_model("rand_tail");

    // err_cnt saturation: every repeated 0x61 after the first is rejected
    tx(8'h61, 1'b1);
    while (m_ecnt < 258) tx(8'h61, 1'b1);
    check_model("saturate");

    // Reset during the data bits of byte 4
    tx(8'h01, 1'b1);
    tx(8'h62, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    idle(1);
    model_reset();
    check("midreset.led", 32'(led_out), 32'd0);
    check("midreset.buzzer", 32'(buzzer_out), 32'd0);
    check("midreset.seg7", 32'(seg7_out), 32'h01);
    check("midreset.frame_cnt", 32'(frame_cnt), 32'd0);
    check("midreset.err_cnt", 32'(err_cnt), 32'd0);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2 * CPB);
    tx(8'h61, 1'b1); tx(8'h01, 1'b1); tx(8'h62, 1'b1); tx(8'h00, 1'b1); tx(8'h63, 1'b1); tx(8'h33, 1'b1);
    check("post_reset.frame_cnt", 32'(frame_cnt), 32'd1);
    check("post_reset.seg7", 32'(seg7_out), 32'h33);
    check_model("post_reset");

    check("pulse_overlap", 32'(mon_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
